// File: rtl/dot_accum.sv
// Dot-product accumulator behind the 2-stage mult_fast pipeline: tags track accepted
// pairs, products are summed per vector, and results queue in a 2-entry FIFO.
module dot_accum #(
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic             op_last,
  output logic             op_ready,
  input  logic [7:0]       p,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_sum,
  output logic [7:0]       res_cnt,
  output logic             res_ovf
);

  typedef struct packed {
    logic vld;
    logic last;
  } tag_t;

  typedef struct packed {
    logic [ACC_W-1:0] sum;
    logic [7:0]       cnt;
    logic             ovf;
  } res_t;

  tag_t             tag_q [3];
  tag_t             tag_d [3];
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  res_t             mem_q [2];
  res_t             mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;

  logic [ACC_W:0]   wide_sum;
  logic [7:0]       cnt_nxt;
  logic             ovf_nxt;
  logic             push, pop;
  logic [2:0]       credits_used;
  res_t             new_res;

  always_comb begin
    // Every last-tagged pair in flight already owns a FIFO slot.
    credits_used = {1'b0, count_q}
                 + {2'b0, tag_q[0].vld & tag_q[0].last}
                 + {2'b0, tag_q[1].vld & tag_q[1].last}
                 + {2'b0, tag_q[2].vld & tag_q[2].last};
    op_ready = (credits_used < 3'd2);
  end

  assign res_valid = (count_q != 2'd0);
  assign res_sum   = mem_q[rd_ptr_q].sum;
  assign res_cnt   = mem_q[rd_ptr_q].cnt;
  assign res_ovf   = mem_q[rd_ptr_q].ovf;

  always_comb begin
    tag_d[0].vld  = op_valid && op_ready;
    tag_d[0].last = op_last;
    tag_d[1]      = tag_q[0];
    tag_d[2]      = tag_q[1];

    wide_sum = {1'b0, acc_q} + (ACC_W+1)'(p);
    cnt_nxt  = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;
    ovf_nxt  = ovf_q | wide_sum[ACC_W];

    new_res.sum = wide_sum[ACC_W-1:0];
    new_res.cnt = cnt_nxt;
    new_res.ovf = ovf_nxt;

    push = tag_q[2].vld && tag_q[2].last;
    pop  = res_valid && res_ready;

    acc_d = acc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (tag_q[2].vld) begin
      if (tag_q[2].last) begin
        acc_d = '0;
        cnt_d = '0;
        ovf_d = 1'b0;
      end else begin
        acc_d = wide_sum[ACC_W-1:0];
        cnt_d = cnt_nxt;
        ovf_d = ovf_nxt;
      end
    end

    mem_d[0] = mem_q[0];
    mem_d[1] = mem_q[1];
    if (push) mem_d[wr_ptr_q] = new_res;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    count_d  = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) tag_q[i] <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < 3; i++) tag_q[i] <= tag_d[i];
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_dot_accum.sv
// Bench for dot_accum: a mult_fast model feeds two instances (ACC_W=16 and 8);
// a reference accumulator queues expected results that a monitor pops on each handshake.
module tb_dot_accum;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_valid = 1'b0;
  logic        op_last = 1'b0;
  logic        res_ready = 1'b1;
  logic [3:0]  a_in = '0, b_in = '0;
  logic [7:0]  r0 = '0, r1 = '0, p = '0;

  logic        op_ready16, res_valid16, res_ovf16;
  logic [15:0] res_sum16;
  logic [7:0]  res_cnt16;
  logic        op_ready8, res_valid8, res_ovf8;
  logic [7:0]  res_sum8;
  logic [7:0]  res_cnt8;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  typedef struct {
    int unsigned sum16;
    int unsigned sum8;
    int unsigned cnt;
    bit          ovf16;
    bit          ovf8;
  } exp_t;

  exp_t        q [$];
  int unsigned m_acc16 = 0, m_acc8 = 0, m_cnt = 0;
  bit          m_ovf16 = 0, m_ovf8 = 0;

  always #5 clk = ~clk;

  // mult_fast: inputs sampled at edge k, P updated at edge k+2
  always @(posedge clk) begin
    r0 <= 8'(a_in) * 8'(b_in);
    r1 <= r0;
    p  <= r1;
  end

  dot_accum #(.ACC_W(16)) dut16 (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_last(op_last), .op_ready(op_ready16),
    .p(p), .res_valid(res_valid16), .res_ready(res_ready), .res_sum(res_sum16),
    .res_cnt(res_cnt16), .res_ovf(res_ovf16)
  );

  dot_accum #(.ACC_W(8)) dut8 (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_last(op_last), .op_ready(op_ready8),
    .p(p), .res_valid(res_valid8), .res_ready(res_ready), .res_sum(res_sum8),
    .res_cnt(res_cnt8), .res_ovf(res_ovf8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_acc16 = 0; m_acc8 = 0; m_cnt = 0; m_ovf16 = 0; m_ovf8 = 0;
  endtask

  task automatic model_add(input int unsigned prod, input bit last);
    int unsigned w16, w8, c;
    bit o16, o8;
    exp_t e;
    w16 = m_acc16 + prod;
    w8  = m_acc8 + prod;
    o16 = m_ovf16 | (w16 > 65535);
    o8  = m_ovf8 | (w8 > 255);
    c   = (m_cnt < 255) ? m_cnt + 1 : 255;
    if (last) begin
      e.sum16 = w16 % 65536; e.sum8 = w8 % 256; e.cnt = c; e.ovf16 = o16; e.ovf8 = o8;
      q.push_back(e);
      model_clear();
    end else begin
      m_acc16 = w16 % 65536; m_acc8 = w8 % 256; m_cnt = c; m_ovf16 = o16; m_ovf8 = o8;
    end
  endtask

  // Hold the pair until accepted; non-accepted cycles leave junk on A/B afterwards.
  task automatic send(input int unsigned a, input int unsigned b, input bit last);
    bit rdy;
    int n;
    a_in = 4'(a); b_in = 4'(b); op_last = last; op_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      rdy = op_ready16;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 200);
    if (!rdy) chk("accept_timeout", 32'd0, 32'd1);
    else model_add(a * b, last);
    op_valid = 1'b0;
    op_last  = 1'b0;
    a_in = 4'($urandom_range(1, 15));
    b_in = 4'($urandom_range(1, 15));
  endtask

  task automatic bubble();
    op_valid = 1'b0;
    a_in = 4'($urandom_range(1, 15));
    b_in = 4'($urandom_range(1, 15));
    cycle();
  endtask

  always @(negedge clk) begin
    if (!rst && res_valid16 && res_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_result", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sum16", 32'(res_sum16), e.sum16);
        chk("cnt16", 32'(res_cnt16), e.cnt);
        chk("ovf16", 32'(res_ovf16), 32'(e.ovf16));
        chk("valid8", 32'(res_valid8), 32'd1);
        chk("sum8", 32'(res_sum8), e.sum8);
        chk("cnt8", 32'(res_cnt8), e.cnt);
        chk("ovf8", 32'(res_ovf8), 32'(e.ovf8));
      end
    end
  end

  initial begin
    // reset state
    repeat (2) cycle();
    chk("rst_res_valid", 32'(res_valid16), 32'd0);
    chk("rst_res_sum", 32'(res_sum16), 32'd0);
    chk("rst_res_cnt", 32'(res_cnt16), 32'd0);
    chk("rst_res_ovf", 32'(res_ovf16), 32'd0);
    chk("rst_op_ready", 32'(op_ready16), 32'd1);
    chk("rst_op_ready8", 32'(op_ready8), 32'd1);
    rst = 1'b0;
    cycle();

    // single-element vector latency: valid only after edge k+3, gone after k+4
    send(3, 5, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      cycle();
      if (i < 3) chk("lat_early_valid", 32'(res_valid16), 32'd0);
      if (i == 3) begin
        chk("lat_k3_valid", 32'(res_valid16), 32'd1);
        chk("lat_k3_sum", 32'(res_sum16), 32'd15);
      end
      if (i == 4) chk("lat_k4_drop", 32'(res_valid16), 32'd0);
    end

    // 4 x (15*15) back-to-back
    send(15, 15, 1'b0);
    send(15, 15, 1'b0);
    send(15, 15, 1'b0);
    send(15, 15, 1'b1);
    repeat (6) cycle();

    // bubbles contribute nothing
    send(2, 3, 1'b0);
    bubble();
    send(4, 4, 1'b0);
    bubble();
    send(1, 7, 1'b1);
    repeat (6) cycle();

    // 8-bit wrap with carry, then a clean vector
    send(15, 15, 1'b0);
    send(15, 15, 1'b1);
    send(1, 1, 1'b1);
    repeat (8) cycle();
    chk("drain_a", q.size(), 32'd0);

    // credit throttling with downstream stalled
    res_ready = 1'b0;
    send(2, 2, 1'b1);
    send(3, 3, 1'b1);
    chk("credit_op_ready_low", 32'(op_ready16), 32'd0);
    fork
      send(4, 4, 1'b1);
      begin
        repeat (8) cycle();
        chk("stall_op_ready_low", 32'(op_ready16), 32'd0);
        chk("stall_res_valid", 32'(res_valid16), 32'd1);
        chk("stall_head_sum", 32'(res_sum16), 32'd4);
        res_ready = 1'b1;
      end
    join
    repeat (10) cycle();
    chk("drain_b", q.size(), 32'd0);

    // reset discards a partial vector
    send(7, 7, 1'b0);
    send(9, 9, 1'b0);
    send(6, 6, 1'b0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    model_clear();
    chk("post_rst_valid", 32'(res_valid16), 32'd0);
    chk("post_rst_ready", 32'(op_ready16), 32'd1);
    send(5, 5, 1'b1);
    repeat (8) cycle();
    chk("drain_c", q.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/dot_accum.md
# dot_accum

Dot-product accumulator that sits directly downstream of the pipelined 4x4 multiplier `mult_fast`. It tracks which operand pairs entered the multiplier and with what tags, sums the products of each vector, and delivers one result per vector. Delivery uses a valid/ready handshake through a 2-entry result FIFO. Because the multiplier cannot stall, a credit check on `op_ready` throttles upstream so that no result is ever dropped.

## Interface
- `ACC_W`, default 16: accumulator and result width; the sum wraps modulo 2^ACC_W.
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `op_valid`  in  1  upstream presents an operand pair on the multiplier's A/B this cycle.
- `op_last`  in  1  the pair is the final element of its vector; qualified by `op_valid`.
- `op_ready`  out  1  block can accept a pair; transfer happens when `op_valid && op_ready` at posedge.
- `p`  in  8  product output P of `mult_fast`.
- `res_valid`  out  1  FIFO head holds a result.
- `res_ready`  in  1  downstream accepts the head; pop happens when `res_valid && res_ready` at posedge.
- `res_sum`  out  ACC_W  sum of the vector's products, modulo 2^ACC_W.
- `res_cnt`  out  8  number of elements in the vector; saturates at 255.
- `res_ovf`  out  1  at least one accumulation in the vector carried out of ACC_W.

## Operation
- Upstream drives A/B to `mult_fast` every cycle. The block never drives A/B.
- Products of non-accepted cycles are ignored.
- Tag pipeline: 3 registers t0..t2, each holding {valid, last}.
  - t0 loads {`op_valid && op_ready`, `op_last`}.
  - t1 <= t0 and t2 <= t1 every cycle.
  - This matches the multiplier: inputs are sampled at edge k and P is registered at edge k+2.
- Accumulate at every edge where t2.valid = 1:
  - wide sum = acc + zero-extended `p`;
  - cnt_next = min(cnt+1, 255);
  - ovf_next = ovf | carry-out of the sum.
  - If t2.last = 0: acc, cnt and ovf take the new values.
  - If t2.last = 1: push {sum mod 2^ACC_W, cnt_next, ovf_next} into the FIFO and clear acc, cnt and ovf to 0.
- Result FIFO: 2 entries, first-in first-out. `res_*` always show the head entry.
  - Push and pop may occur in the same edge: occupancy stays the same and order is preserved.
  - A pop while the FIFO is empty is impossible, because pops are qualified by `res_valid`.
- Credit rule: `op_ready` = (fifo_count + number of t0..t2 with valid&last) < 2.
  - `op_ready` is a combinational function of registers only.
  - It never depends on `op_valid` or `res_ready`.
  - A push therefore never finds the FIFO full.
- Non-last elements still need `op_ready` = 1 to be accepted.
- An accepted element with `op_last` = 0 never consumes a credit.
- A vector of length 1 is legal: its single pair carries `op_last` = 1.
- Reset (`rst` = 1 at posedge) clears t0..t2, acc, cnt, ovf and the FIFO.
  - A partially accumulated vector is discarded.
  - In-flight products are discarded.
  - Queued results are discarded.

## Timing
- Reset values:
  - `res_valid` = 0
  - `res_sum` = 0
  - `res_cnt` = 0
  - `res_ovf` = 0
  - `op_ready` = 1
- A pair accepted at edge k has its product added at edge k+3.
- If that pair is last and the FIFO was empty, `res_valid` = 1 from edge k+3.
- The FIFO can then be popped at edge k+4 at the earliest.
- Throughput: one element per cycle while `op_ready` = 1. Gaps in `op_valid` are bubbles and do not affect sums.
- With `res_ready` held at 0:
  - At most 2 last-tagged pairs are in flight or queued.
  - `op_ready` drops in the cycle after the second last is accepted.
- `op_ready` rises in the cycle after the pop that frees a credit.

## Test plan
- Reset, then accept A=3, B=5 with `op_last` = 1 at edge k; hold `res_ready` = 1.
  - Required: `res_valid` rises at edge k+3 with sum=15, cnt=1, ovf=0.
  - Required: `res_valid` drops after edge k+4.
- 4-element vector of 15x15, back-to-back, last on the 4th; ACC_W=16.
  - Required: sum=900, cnt=4, ovf=0.
- Vector (2x3, bubble, 4x4, bubble, 1x7 last).
  - Required: sum=29, cnt=3; the bubbles contribute nothing.
- ACC_W=8, vector 15x15, 15x15 last.
  - Required: sum=194, ovf=1.
  - Required: the next vector, 1x1 last, gives sum=1, ovf=0.
- `res_ready` = 0; offer three length-1 vectors (2x2, 3x3, 4x4) on consecutive cycles.
  - Required: the first two are accepted; `op_ready` = 0 and the third is held.
  - Required: after `res_ready` = 1, results pop as 4, then 9; the third is accepted and pops as 16.
  - Required: no result is lost or reordered.
- Accept 3 elements of a vector, assert `rst` for one edge, then send vector 5x5 last.
  - Required: `res_valid` = 0 after the reset.
  - Required: the later result is sum=25, cnt=1, with no carry-over from before reset.
